// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   mode_e         : per-beat operation select (ADD = 0, SUB = 1).
//   DEFAULT_WIDTH  : default operand/result width.
//   DEFAULT_CHUNK  : default bits resolved per pipeline stage.
//   width_ok()     : configuration legality test used at elaboration.
package add_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  // A width is legal only when it splits into whole, non-empty chunks.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/carry_chunk.sv
// Combinational CHUNK-bit ripple-carry slice.
//   a, b  : operand slices (b already inverted for subtraction)
//   cin   : carry into bit 0 of the slice
//   s     : sum slice
//   cout  : carry out of the slice MSB
module carry_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor.
// The WIDTH-bit operation is split into STAGES = WIDTH/CHUNK ripple slices,
// one register stage per slice. Stage k resolves sum bits [k*CHUNK +: CHUNK]
// from the carry registered by stage k-1; operands and the partial sum ride
// along in skew registers so each beat carries its own mode and carry-in.
//
// Ports:
//   clk, rst_n             : clock (rising edge), async active-low reset
//   in_valid / in_ready    : operand beat handshake
//   in_a, in_b             : operands
//   in_cin                 : carry-in (ADD only; SUB forces carry-in 1)
//   in_mode                : ADD / SUB (mode_e)
//   out_valid / out_ready  : result beat handshake
//   out_sum                : result bits, modulo 2^WIDTH
//   out_cout               : carry out of the MSB (SUB: 1 = no borrow)
//   out_ovf                : signed overflow
//
// Handshake: a beat transfers on in_valid && in_ready, a result retires on
// out_valid && out_ready. The whole pipe advances together when
// en = !out_valid || out_ready; in_ready equals en, so a stalled output
// freezes every stage and no new beat is taken. Retire and accept may
// happen in the same cycle. An empty input slot while en=1 enters stage 0
// as a bubble and travels down the pipe like any other beat.
module pipelined_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  mode_e            in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Per-stage register contents. b holds the already-inverted operand for
  // SUB beats, so later stages never need to know the mode.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

  stage_t              st_q   [STAGES];
  stage_t              nxt_st [STAGES];
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   nxt_v;
  logic                en;

  assign en       = !valid_q[LAST] || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_src;
    logic             c_src;
    logic [CHUNK-1:0] s_slice;
    logic             c_slice;
    logic [WIDTH-1:0] sum_new;

    if (k == 0) begin : g_first
      // Capture point: B is inverted once here, and SUB injects the +1
      // through the stage-0 carry instead of in_cin.
      assign a_src   = in_a;
      assign b_src   = (in_mode == SUB) ? ~in_b : in_b;
      assign sum_src = '0;
      assign c_src   = (in_mode == SUB) ? 1'b1 : in_cin;
      assign nxt_v[k] = in_valid;
    end else begin : g_rest
      assign a_src   = st_q[k-1].a;
      assign b_src   = st_q[k-1].b;
      assign sum_src = st_q[k-1].sum;
      assign c_src   = st_q[k-1].carry;
      assign nxt_v[k] = valid_q[k-1];
    end

    carry_chunk #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a    (a_src[k*CHUNK +: CHUNK]),
      .b    (b_src[k*CHUNK +: CHUNK]),
      .cin  (c_src),
      .s    (s_slice),
      .cout (c_slice)
    );

    // Splice this stage's freshly resolved bits into the travelling sum.
    always_comb begin
      sum_new                    = sum_src;
      sum_new[k*CHUNK +: CHUNK]  = s_slice;
    end

    assign nxt_st[k] = '{a: a_src, b: b_src, sum: sum_new, carry: c_slice};
  end

  // Data registers only load when a real beat arrives, so bubbles leave the
  // previous contents in place instead of toggling on garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (en) begin
      valid_q <= nxt_v;
      for (int k = 0; k < STAGES; k++) begin
        if (nxt_v[k]) begin
          st_q[k] <= nxt_st[k];
        end
      end
    end
  end

  // Result comes straight from the last stage register, so it is stable
  // whenever the pipe is held.
  assign out_valid = valid_q[LAST];
  assign out_sum   = st_q[LAST].sum;
  assign out_cout  = st_q[LAST].carry;
  // Overflow: operands of equal sign producing a sum of the other sign.
  assign out_ovf   = (st_q[LAST].a[WIDTH-1] == st_q[LAST].b[WIDTH-1]) &&
                     (st_q[LAST].sum[WIDTH-1] != st_q[LAST].a[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (WIDTH=16, CHUNK=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge or 1 time unit after a rising edge.
module tb_pipelined_add_sub;
  import add_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  mode_e        in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  // Directed operand table for the streaming scenarios.
  logic [W-1:0] tv_a [16] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000,
                              16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0,
                              16'h5555, 16'hAAAA, 16'h0000, 16'h8001,
                              16'h3C3C, 16'hC3C3, 16'h7FFE, 16'h0010};
  logic [W-1:0] tv_b [16] = '{16'h0002, 16'h0001, 16'h0001, 16'h0001,
                              16'h1111, 16'h5433, 16'hF0F1, 16'h0F10,
                              16'h2AAB, 16'h5555, 16'h0001, 16'h7FFF,
                              16'hC3C4, 16'h3C3C, 16'hFFFF, 16'h0010};
  logic         tv_cin [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  mode_e        tv_mode [16] = '{ADD, ADD, ADD, SUB, ADD, SUB, ADD, SUB,
                                 ADD, SUB, SUB, ADD, SUB, ADD, SUB, SUB};

  pipelined_add_sub #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, then sign-based overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input mode_e mode);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         c0;
    bb   = (mode == SUB) ? ~b : b;
    c0   = (mode == SUB) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    return {((a[W-1] == bb[W-1]) && (full[W-1] != a[W-1])), full[W], full[W-1:0]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_mode = ADD; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b, need all 0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b need 0", out_valid);
    end
  endtask

  // One isolated beat: latency, result fields, and single retirement.
  task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input mode_e mode, input logic [W-1:0] es,
                         input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_cin = cin; in_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready: got %b need 1", name, in_ready);
    end
    @(posedge clk); #1;            // acceptance edge just passed
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_mode = ADD;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles need 4", name, lat);
    end
    checks++;
    if (out_sum !== es) begin
      failures++;
      $display("FAIL %s sum: got %h need %h", name, out_sum, es);
    end
    checks++;
    if (out_cout !== ec) begin
      failures++;
      $display("FAIL %s cout: got %b need %b", name, out_cout, ec);
    end
    checks++;
    if (out_ovf !== eo) begin
      failures++;
      $display("FAIL %s ovf: got %b need %b", name, out_ovf, eo);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s single_retire: out_valid got %b need 0", name, out_valid);
    end
  endtask

  task automatic test_add();
    test_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b0);
    test_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b1);
    test_op("add_cin",   16'h1234, 16'h1111, 1'b1, ADD, 16'h2346, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    test_op("sub_neg",   16'h0005, 16'h0007, 1'b0, SUB, 16'hFFFE, 1'b0, 1'b0);
    test_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, SUB, 16'h7FFF, 1'b1, 1'b1);
    // carry-in must be ignored in SUB mode
    test_op("sub_cin",   16'h0010, 16'h0010, 1'b1, SUB, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] got;
    logic [W+1:0] exp;
    int idx, nres, first_c, last_c;
    exp_q.delete();
    idx = 0; nres = 0; first_c = -1; last_c = -1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 16; cyc++) begin
      if (idx < 16) begin
        in_valid = 1'b1; in_a = tv_a[idx]; in_b = tv_b[idx];
        in_cin = tv_cin[idx]; in_mode = tv_mode[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid === 1'b1) begin
        got = {out_ovf, out_cout, out_sum};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: unexpected result %h", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL b2b_result%0d: got %h need %h", nres, got, exp);
          end
        end
        nres++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if (idx < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready: got %b need 1 at beat %0d", in_ready, idx);
        end else begin
          exp_q.push_back(model(tv_a[idx], tv_b[idx], tv_cin[idx], tv_mode[idx]));
          idx++;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (nres !== 16) begin
      failures++;
      $display("FAIL b2b_count: got %0d results need 16", nres);
    end
    checks++;
    if (last_c - first_c !== 15) begin
      failures++;
      $display("FAIL b2b_rate: results spread over %0d cycles need 15", last_c - first_c);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_leftover: %0d expected results never seen", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic [W+1:0] got;
    logic [W+1:0] exp;
    logic [W+1:0] snap;
    int idx, nres;
    exp_q.delete();
    idx = 0; nres = 0; snap = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && nres < 10; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (idx < 10) begin
        in_valid = 1'b1; in_a = tv_a[15-idx]; in_b = tv_b[15-idx];
        in_cin = tv_cin[15-idx]; in_mode = tv_mode[15-idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_in_ready: got %b need 0 at cycle %0d", in_ready, cyc);
        end
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_out_valid: got %b need 1 at cycle %0d", out_valid, cyc);
        end
        if (cyc == 5) begin
          snap = {out_ovf, out_cout, out_sum};
        end else begin
          checks++;
          if ({out_ovf, out_cout, out_sum} !== snap) begin
            failures++;
            $display("FAIL stall_frozen: got %h need %h at cycle %0d",
                     {out_ovf, out_cout, out_sum}, snap, cyc);
          end
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        got = {out_ovf, out_cout, out_sum};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra: unexpected result %h", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL stall_result%0d: got %h need %h", nres, got, exp);
          end
        end
        nres++;
      end
      if (idx < 10 && in_ready === 1'b1) begin
        exp_q.push_back(model(tv_a[15-idx], tv_b[15-idx], tv_cin[15-idx], tv_mode[15-idx]));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (nres !== 10 || idx !== 10) begin
      failures++;
      $display("FAIL stall_count: accepted %0d retired %0d need 10 and 10", idx, nres);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL stall_leftover: %0d expected results never seen", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Four beats enter; the first reaches the output and is held there,
    // the other three are still inside the pipe.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a     = (i == 0) ? 16'h8000 : tv_a[i+4];
      in_b     = (i == 0) ? 16'h0001 : tv_b[i+4];
      in_cin   = 1'b0;
      in_mode  = (i == 0) ? SUB : ADD;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL midrst_prefill: got v=%b sum=%h c=%b o=%b need 1 7fff 1 1",
               out_valid, out_sum, out_cout, out_ovf);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== '0) begin
      failures++;
      $display("FAIL midrst_clear: got v=%b sum=%h c=%b o=%b need all 0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_stale: out_valid got %b need 0 at cycle %0d", out_valid, i);
      end
    end
    test_op("midrst_new", 16'h0F0F, 16'h00F1, 1'b0, ADD, 16'h1000, 1'b0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor. It generalises the team's fixed-width ripple adder to WIDTH bits, split into CHUNK-bit ripple slices with one register stage per slice. Adds a per-operation add/sub mode, carry-in, and signed overflow, behind a valid/ready stream handshake. It is the datapath arithmetic unit feeding the accumulator and ALU blocks.

## Interface
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (default 4).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; used only in ADD mode.
- in_mode  in  1  0 = ADD, 1 = SUB (mode_e from package).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of the MSB. In SUB mode, 1 = no borrow.
- out_ovf  out  1  signed overflow.

## Operation
- ADD: result = in_a + in_b + in_cin.
- SUB: result = in_a + ~in_b + 1. in_cin is ignored.
- Stage k (0..STAGES-1) resolves bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1. Stage 0 carry-in = in_cin (ADD) or 1 (SUB).
- Unprocessed operand bits and already-resolved sum bits travel alongside in skew registers.
- B is inverted at input capture, not per stage.
- out_cout is the carry out of the final slice.
- out_ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the possibly inverted B.
- All arithmetic is modulo 2^WIDTH. No saturation.
- Each stage holds a valid bit. Bubbles propagate as invalid stages; they are not collapsed.

## Timing
- Reset, asynchronous: all stage valid bits 0, all data registers 0. Outputs: out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 once rst_n is high.
- Global advance: en = !out_valid || out_ready. in_ready = en, combinational from out_ready and the final valid bit.
- Handshake rules:
  - A beat transfers on in_valid && in_ready.
  - A result retires on out_valid && out_ready.
  - out_sum, out_cout and out_ovf are stable while out_valid && !out_ready.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1 (STAGES cycles of registered stages; the output is taken from the last stage register).
- Throughput: one beat per cycle while out_ready=1.
- Stall: when out_valid && !out_ready, every stage holds, in_ready=0, and no input is taken.
- Simultaneous retire and accept in the same cycle is permitted and required for full throughput.
- in_valid=0 with en=1 inserts a bubble into stage 0.
- Reset mid-operation discards all in-flight beats. No partial results appear after reset release.
- Mode and cin travel with their beat; changing in_mode between beats never affects earlier beats.

## Structure
- Package add_pkg holds:
  - mode_e enum (ADD=0, SUB=1).
  - Default WIDTH and CHUNK localparams.
  - Elaboration check: WIDTH % CHUNK == 0.
- Sub-module carry_chunk: combinational CHUNK-bit ripple slice with inputs a, b, cin and outputs s, cout. It is instantiated STAGES times by a generate loop.
- The top holds the stage registers, valid bits, skew registers and handshake logic.

## Test plan
All values use WIDTH=16, CHUNK=4.
- ADD 0xFFFF + 0x0001, cin=0, out_ready=1 -> out_sum=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- ADD 0x7FFF + 0x0001 -> 0x8000, cout=0, ovf=1. ADD 0x1234 + 0x1111, cin=1 -> 0x2346, cout=0, ovf=0.
- SUB 0x0005 - 0x0007 -> 0xFFFE, cout=0, ovf=0. SUB 0x8000 - 0x0001 -> 0x7FFF, cout=1, ovf=1.
- 16 back-to-back random beats with out_ready=1 -> one result per cycle, in order, matching the reference model; in_ready stays 1.
- Fill the pipe, then drop out_ready for 5 cycles -> in_ready=0, outputs frozen, no beat lost or duplicated after out_ready returns.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 and all outputs 0 immediately. After release, no stale results, and a new beat appears after 4 cycles.
